sha256_msg_schedule: RTL
========================

Name: sha256_msg_schedule

Overview:
- Upstream stage of the SHA-256 compressor.
- Accepts one 512-bit message block as 16 serial 32-bit words and holds them in a 16-entry circular buffer.
- Emits the 64-word message schedule W[0..63] in round order, one word per accepted handshake, with the round index alongside. The compressor consumes these W words.
- Words 16..63 are expanded in place: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].

Parameters:
- WORDS_PER_BLOCK, 16, input words per block; fixed by the algorithm; sizes the buffer and load counter.
- ROUNDS, 64, schedule words emitted per block; sizes the 6-bit round index.

Ports:
- CLK  in  1  rising-edge clock; single clock domain.
- RESET  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to CLK.
- LOAD_VALID  in  1  WORD_IN is valid.
- LOAD_READY  out  1  block accepts an input word.
- WORD_IN  in  32  message word, big-endian, word 0 first.
- W_VALID  out  1  W_OUT / I_OUT are valid.
- W_READY  in  1  compressor takes the current word.
- W_OUT  out  32  schedule word W[I_OUT].
- I_OUT  out  6  round index 0..63.
- DONE  out  1  one-cycle pulse after W[63] is accepted.

Behaviour:
- Reset (RESET=0) values:
  - state=IDLE, load count=0, round index=0.
  - LOAD_READY=0, W_VALID=0, DONE=0, I_OUT=0.
  - W_OUT=0. Buffer contents are don't-care.
- States: IDLE -> LOAD -> RUN -> FIN -> LOAD.
  - IDLE: one cycle after reset release, then go to LOAD.
  - LOAD: LOAD_READY=1. Each cycle with LOAD_VALID&LOAD_READY writes WORD_IN into buf[count] and increments count. The 16th accept goes to RUN and clears count.
  - RUN: W_VALID=1, I_OUT=t.
    - t<16: W_OUT=buf[t].
    - t>=16: W_OUT is the expansion computed combinationally from buf[(t-2)&15], buf[(t-7)&15], buf[(t-15)&15] and buf[t&15].
    - On W_VALID&W_READY with t>=16, write W_OUT into buf[t&15], then increment t.
    - Accepting t=63 goes to FIN.
  - FIN: DONE=1 and W_VALID=0 for exactly one cycle, then go to LOAD.
- s0(x) = ROTR7 ^ ROTR18 ^ SHR3. s1(x) = ROTR17 ^ ROTR19 ^ SHR10. All additions are mod 2^32; carries are discarded.
- Latency: W_VALID rises the cycle after the 16th load accept. With W_READY held high, W[0..63] are emitted on 64 consecutive cycles.
- Backpressure: while W_VALID=1 and W_READY=0, W_OUT and I_OUT stay stable and the buffer is not written.
- LOAD_READY=0 in IDLE, RUN and FIN. LOAD_VALID is ignored in those states; no word is accepted.
- LOAD_VALID=0 mid-load: hold the count; partial blocks persist indefinitely.
- Reset asserted mid-LOAD or mid-RUN: return to IDLE at once. The partial block is discarded and DONE is not pulsed.
- The index wraps only via the FIN state; I_OUT never exceeds 63.

Optional Feature:
- SHA256_KROM_EN defined:
  - Adds output port K_OUT (out, 32) driven from an internal 64-entry round-constant ROM indexed by I_OUT.
  - K_OUT is valid under the same W_VALID/W_READY rules as W_OUT and is 0 when W_VALID=0.
  - Removes the compressor's external K table.
- Undefined: no K_OUT port and no ROM; K is supplied externally by index I_OUT.

Test Plan:
- "Hello world!" padded block (W[0]=0x48656c6c, W[1]=0x6f20776f, W[2]=0x726c6421, W[3]=0x80000000, W[4..14]=0, W[15]=0x00000060) loaded on consecutive cycles, W_READY=1 -> W[0..15] echoed in order, I_OUT 0..15; W[16]=0x17470237. DONE pulses 64 cycles after the first W_VALID.
- Same block with W_READY toggled 1,0,0,1,... -> W_OUT/I_OUT stable during stalls; the sequence is identical to the first test; DONE is delayed by the number of stall cycles.
- LOAD_VALID held high during RUN with WORD_IN=0xFFFFFFFF -> LOAD_READY=0 and the schedule is unaffected; after DONE, the next block loads and W[0] of the new block is emitted.
- RESET pulsed low at I_OUT=30 -> W_VALID=0 and I_OUT=0 immediately, no DONE; a reload reproduces the full correct schedule.
- Load paused after 7 words for 10 cycles -> no W_VALID until the 16th word; output matches the first test.
- With SHA256_KROM_EN -> K_OUT=0x428a2f98 at I_OUT=0 and 0xc67178f2 at I_OUT=63; K_OUT=0 when idle.

Source files
------------

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: loads a 16-word block into a circular buffer and emits W[0..63], expanding in place.
// Optional SHA256_KROM_EN adds K_OUT, the round constant for I_OUT.
module sha256_msg_schedule #(
  parameter int WORDS_PER_BLOCK = 16,
  parameter int ROUNDS = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        LOAD_VALID,
  output logic        LOAD_READY,
  input  logic [31:0] WORD_IN,
  output logic        W_VALID,
  input  logic        W_READY,
  output logic [31:0] W_OUT,
  output logic [5:0]  I_OUT,
  output logic        DONE
`ifdef SHA256_KROM_EN
  ,
  output logic [31:0] K_OUT
`endif
);
  localparam int CW = $clog2(WORDS_PER_BLOCK);
  localparam int IW = $clog2(ROUNDS);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] t_q, t_d;
  logic [31:0] buf_q [WORDS_PER_BLOCK];
  logic [31:0] buf_d [WORDS_PER_BLOCK];
  logic [31:0] w_exp;
  logic [CW-1:0] ti;
  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
  assign ti = t_q[CW-1:0];
  assign w_exp = s1(buf_q[ti - CW'(2)]) + buf_q[ti - CW'(7)] + s0(buf_q[ti - CW'(15)]) + buf_q[ti];
  assign LOAD_READY = state_q == LOAD;
  assign W_VALID = state_q == RUN;
  assign DONE = state_q == FIN;
  assign I_OUT = t_q;
  assign W_OUT = !W_VALID ? '0 : t_q < IW'(WORDS_PER_BLOCK) ? buf_q[ti] : w_exp;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    t_d = t_q;
    buf_d = buf_q;
    if (state_q == IDLE || state_q == FIN) state_d = LOAD;
    if (LOAD_READY && LOAD_VALID) begin
      buf_d[cnt_q] = WORD_IN;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(WORDS_PER_BLOCK - 1)) state_d = RUN;
    end
    if (W_VALID && W_READY) begin
      if (t_q >= IW'(WORDS_PER_BLOCK)) buf_d[ti] = w_exp;
      t_d = t_q + IW'(1);
      if (t_q == IW'(ROUNDS - 1)) state_d = FIN;
    end
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q <= '0;
      t_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      t_q <= t_d;
    end
  end
  // Buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge CLK) buf_q <= buf_d;
`ifdef SHA256_KROM_EN
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  assign K_OUT = W_VALID ? K[I_OUT] : '0;
`endif
endmodule
